// File: rtl/nic_pkg.sv
// Shared NIC ring packet formats, type codes and node-id constants.
package nic_pkg;

    typedef enum logic [3:0] {
        PT_NULL  = 4'd0,
        PT_READ  = 4'd1,
        PT_WRITE = 4'd2,
        PT_AREAD = 4'd3,
        PT_ACK   = 4'd4,
        PT_ERR   = 4'd5,
        PT_IRQ   = 4'd6
    } ptype_t;

    typedef struct packed {
        logic [5:0]  did;
        logic [5:0]  sid;
        logic [5:0]  age;
        logic        ack;
        ptype_t      typ;
        logic [7:0]  asid;
        logic        mmus;
        logic        ios;
        logic        iops;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } packet_t;

    typedef struct packed {
        logic [5:0] did;
        logic [5:0] sid;
        logic [5:0] age;
        logic [2:0] level;
        logic [7:0] vector;
    } ipacket_t;

    localparam logic [5:0] DID_EMPTY       = 6'd0;
    localparam logic [5:0] DID_GLOBAL      = 6'd62;
    localparam logic [5:0] DID_BCAST       = 6'd63;
    localparam logic [5:0] AGE_MAX_DEFAULT = 6'd60;

    // Packet types that leave a slave cycle waiting for a response.
    function automatic logic fnIsRequest(input ptype_t typ);
        return (typ == PT_READ) || (typ == PT_AREAD) || (typ == PT_WRITE);
    endfunction

endpackage

// File: rtl/rf68000_ring_ager_fifo.sv
// Small packet FIFO holding error responses waiting for a free response-ring slot.
module rf68000_ring_ager_fifo
    import nic_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    push_i,
    input  logic    pop_i,
    input  packet_t din_i,
    output logic    full_o,
    output logic    empty_o,
    output packet_t head_o
);

    localparam int AW = $clog2(DEPTH);

    packet_t     mem_q [DEPTH];
    logic [AW:0] wptr_q;
    logic [AW:0] rptr_q;
    logic        wr_en;
    logic        rd_en;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign head_o  = mem_q[rptr_q[AW-1:0]];

    // When full, a simultaneous pop frees the head slot the write lands in.
    assign rd_en = pop_i && !empty_o;
    assign wr_en = push_i && (!full_o || rd_en);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wptr_q[AW-1:0]] <= din_i;
                wptr_q                <= wptr_q + 1'b1;
            end
            if (rd_en) rptr_q <= rptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/rf68000_ring_ager.sv
// Ring ager: ages request/response/IPI slots, frees expired ones and (with
// RING_AGER_ERRRSP_EN) answers expired directed requests with PT_ERR responses.
module rf68000_ring_ager
    import nic_pkg::*;
#(
    parameter logic [5:0] ID         = 6'd61,
    parameter logic [5:0] MAX_AGE    = AGE_MAX_DEFAULT,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  packet_t     packet_i,
    output packet_t     packet_o,
    input  packet_t     rpacket_i,
    output packet_t     rpacket_o,
    input  ipacket_t    ipacket_i,
    output ipacket_t    ipacket_o,
    output logic [15:0] drop_cnt_o,
    output logic        ovf_o
);

    logic        req_live, req_exp, req_cnt, req_err;
    logic        rsp_live, rsp_exp, rsp_cnt;
    logic        ipi_live, ipi_exp;
    packet_t     pkt_d, pkt_q;
    packet_t     rpkt_d, rpkt_q;
    packet_t     err_pkt;
    ipacket_t    ipkt_d, ipkt_q;
    logic [16:0] cnt_sum;
    logic [15:0] cnt_d, cnt_q;

`ifdef RING_AGER_ERRRSP_EN
    logic    slot_free;
    logic    fifo_push, fifo_pop, fifo_full, fifo_empty;
    packet_t fifo_head;
    logic    ovf_d, ovf_q;
`endif

    always_comb begin
        req_live = (packet_i.did != DID_EMPTY);
        req_exp  = req_live && (packet_i.age >= MAX_AGE);
        req_cnt  = req_exp && (packet_i.did != DID_BCAST);
        req_err  = req_cnt && fnIsRequest(packet_i.typ);

        rsp_live = (rpacket_i.did != DID_EMPTY);
        rsp_exp  = rsp_live && (rpacket_i.age >= MAX_AGE);
        rsp_cnt  = rsp_exp && (rpacket_i.did != DID_BCAST);

        ipi_live = (ipacket_i.did != DID_EMPTY);
        ipi_exp  = ipi_live && (ipacket_i.age >= MAX_AGE);

        pkt_d = packet_i;
        if (req_exp)       pkt_d.did = DID_EMPTY;
        else if (req_live) pkt_d.age = packet_i.age + 6'd1;

        rpkt_d = rpacket_i;
        if (rsp_exp)       rpkt_d.did = DID_EMPTY;
        else if (rsp_live) rpkt_d.age = rpacket_i.age + 6'd1;
`ifdef RING_AGER_ERRRSP_EN
        // Injected responses are already built with age 0; do not age them.
        if (fifo_pop) rpkt_d = fifo_head;
`endif

        ipkt_d = ipacket_i;
        if (ipi_exp)       ipkt_d.did = DID_EMPTY;
        else if (ipi_live) ipkt_d.age = ipacket_i.age + 6'd1;

        // Reply goes back to the requester, so did comes from the dropped sid.
        err_pkt      = '0;
        err_pkt.typ  = PT_ERR;
        err_pkt.sid  = ID;
        err_pkt.did  = packet_i.sid;
        err_pkt.age  = 6'd0;
        err_pkt.ack  = 1'b1;
        err_pkt.adr  = packet_i.adr;
        err_pkt.asid = packet_i.asid;
        err_pkt.mmus = packet_i.mmus;
        err_pkt.ios  = packet_i.ios;
        err_pkt.iops = packet_i.iops;

        cnt_sum = {1'b0, cnt_q} + {16'd0, req_cnt} + {16'd0, rsp_cnt};
        cnt_d   = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pkt_q  <= '0;
            rpkt_q <= '0;
            ipkt_q <= '0;
            cnt_q  <= '0;
        end else begin
            pkt_q  <= pkt_d;
            rpkt_q <= rpkt_d;
            ipkt_q <= ipkt_d;
            cnt_q  <= cnt_d;
        end
    end

    assign packet_o   = pkt_q;
    assign rpacket_o  = rpkt_q;
    assign ipacket_o  = ipkt_q;
    assign drop_cnt_o = cnt_q;

`ifdef RING_AGER_ERRRSP_EN
    // A slot being freed this cycle is as good as an empty one.
    assign slot_free = (rpacket_i.did == DID_EMPTY) || rsp_exp;
    assign fifo_push = req_err;
    assign fifo_pop  = slot_free && !fifo_empty;

    rf68000_ring_ager_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .push_i (fifo_push),
        .pop_i  (fifo_pop),
        .din_i  (err_pkt),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .head_o (fifo_head)
    );

    assign ovf_d = ovf_q | (fifo_push & fifo_full & ~fifo_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) ovf_q <= 1'b0;
        else       ovf_q <= ovf_d;
    end

    assign ovf_o = ovf_q;
`else
    logic unused_errrsp;
    assign unused_errrsp = ^{err_pkt, req_err, FIFO_DEPTH[0]};
    assign ovf_o         = 1'b0;
`endif

endmodule

// File: tb/tb_rf68000_ring_ager.sv
// Scoreboard bench for rf68000_ring_ager: directed vectors queue hand-computed
// expectations, a monitor compares them one clock after each vector is driven.
module tb_rf68000_ring_ager;
    import nic_pkg::*;

`ifdef RING_AGER_ERRRSP_EN
    localparam bit EN = 1'b1;
`else
    localparam bit EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    packet_t     packet_i, packet_o, rpacket_i, rpacket_o;
    ipacket_t    ipacket_i, ipacket_o;
    logic [15:0] drop_cnt_o;
    logic        ovf_o;

    rf68000_ring_ager dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .packet_i  (packet_i),
        .packet_o  (packet_o),
        .rpacket_i (rpacket_i),
        .rpacket_o (rpacket_o),
        .ipacket_i (ipacket_i),
        .ipacket_o (ipacket_o),
        .drop_cnt_o(drop_cnt_o),
        .ovf_o     (ovf_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        packet_t     p;
        packet_t     r;
        ipacket_t    ip;
        logic [15:0] cnt;
        logic        ovf;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    localparam packet_t  Z  = '0;
    localparam ipacket_t ZI = '0;

    function automatic packet_t mk(input logic [5:0] did, input logic [5:0] sid,
                                   input logic [5:0] age, input ptype_t typ,
                                   input logic [31:0] adr);
        packet_t p;
        p      = '0;
        p.did  = did;
        p.sid  = sid;
        p.age  = age;
        p.typ  = typ;
        p.adr  = adr;
        p.asid = 8'hA5;
        p.mmus = 1'b1;
        p.ios  = 1'b1;
        p.iops = 1'b0;
        p.sel  = 4'hF;
        p.dat  = 32'hDEAD_BEEF;
        return p;
    endfunction

    // Expected error response for a request built by mk() from node `did`.
    function automatic packet_t mkerr(input logic [5:0] did, input logic [31:0] adr);
        packet_t p;
        p      = '0;
        p.typ  = PT_ERR;
        p.sid  = 6'd61;
        p.did  = did;
        p.ack  = 1'b1;
        p.adr  = adr;
        p.asid = 8'hA5;
        p.mmus = 1'b1;
        p.ios  = 1'b1;
        return p;
    endfunction

    function automatic ipacket_t mki(input logic [5:0] did, input logic [5:0] age);
        ipacket_t p;
        p        = '0;
        p.did    = did;
        p.sid    = 6'd1;
        p.age    = age;
        p.level  = 3'd3;
        p.vector = 8'h40;
        return p;
    endfunction

    task automatic chk(input string nm, input exp_t e);
        n_vec++;
        if (packet_o !== e.p || rpacket_o !== e.r || ipacket_o !== e.ip ||
            drop_cnt_o !== e.cnt || ovf_o !== e.ovf) begin
            n_bad++;
            $display("FAIL %s: got p=%h r=%h i=%h cnt=%h ovf=%b | exp p=%h r=%h i=%h cnt=%h ovf=%b",
                     nm, packet_o, rpacket_o, ipacket_o, drop_cnt_o, ovf_o,
                     e.p, e.r, e.ip, e.cnt, e.ovf);
        end
    endtask

    task automatic drive(input packet_t p, input packet_t r, input ipacket_t ip);
        @(negedge clk);
        packet_i  = p;
        rpacket_i = r;
        ipacket_i = ip;
    endtask

    task automatic step(input string nm, input packet_t p, input packet_t r, input ipacket_t ip,
                        input packet_t ep, input packet_t er, input ipacket_t eip,
                        input logic [15:0] ec, input logic eo);
        exp_t e;
        drive(p, r, ip);
        e.name = nm; e.p = ep; e.r = er; e.ip = eip; e.cnt = ec; e.ovf = eo;
        q.push_back(e);
    endtask

    // Monitor: one expectation per clock, checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.name, e);
            end
        end
    end

    initial begin
        exp_t    z;
        packet_t rl, erl;
        packet_t rq;
        ptype_t  ty;

        z.name = "zero"; z.p = Z; z.r = Z; z.ip = ZI; z.cnt = 16'd0; z.ovf = 1'b0;
        rl  = mk(6'd7, 6'd2, 6'd5, PT_ACK, 32'h500);
        erl = mk(6'd7, 6'd2, 6'd6, PT_ACK, 32'h500);

        rst = 1'b1; packet_i = Z; rpacket_i = Z; ipacket_i = ZI;
        #12;
        chk("reset_state", z);
        @(negedge clk);
        rst = 1'b0;

        step("req_age", mk(5, 2, 10, PT_READ, 32'h100), Z, ZI,
             mk(5, 2, 11, PT_READ, 32'h100), Z, ZI, 16'd0, 1'b0);
        step("req_expire", mk(9, 3, 60, PT_READ, 32'h4000_1000), Z, ZI,
             mk(0, 3, 60, PT_READ, 32'h4000_1000), Z, ZI, 16'd1, 1'b0);
        step("err_inject", Z, Z, ZI,
             Z, EN ? mkerr(3, 32'h4000_1000) : Z, ZI, 16'd1, 1'b0);
        step("bcast_drop", mk(63, 1, 60, PT_WRITE, 32'h200), Z, ZI,
             mk(0, 1, 60, PT_WRITE, 32'h200), Z, ZI, 16'd1, 1'b0);
        step("bcast_norsp", Z, Z, ZI, Z, Z, ZI, 16'd1, 1'b0);
        step("ipi_age", Z, Z, mki(2, 7), Z, Z, mki(2, 8), 16'd1, 1'b0);
        step("ipi_expire", Z, Z, mki(5, 60), Z, Z, mki(0, 60), 16'd1, 1'b0);
        step("rsp_age", Z, mk(4, 2, 3, PT_ACK, 32'h300), ZI,
             Z, mk(4, 2, 4, PT_ACK, 32'h300), ZI, 16'd1, 1'b0);
        step("rsp_bcast_exp", Z, mk(63, 2, 61, PT_ACK, 32'h304), ZI,
             Z, mk(0, 2, 61, PT_ACK, 32'h304), ZI, 16'd1, 1'b0);
        step("req_nonreq_exp", mk(8, 2, 60, PT_ACK, 32'h308), Z, ZI,
             mk(0, 2, 60, PT_ACK, 32'h308), Z, ZI, 16'd2, 1'b0);
        step("nonreq_norsp", Z, Z, ZI, Z, Z, ZI, 16'd2, 1'b0);

        // Six expired requests while the response ring stays occupied.
        for (int k = 0; k < 6; k++) begin
            ty = (k % 3 == 0) ? PT_READ : (k % 3 == 1) ? PT_AREAD : PT_WRITE;
            rq = mk(20, 6'(10 + k), 60, ty, 32'h1000_0000 + 32'(k * 4));
            step("ovf_fill", rq, rl, ZI, mk(0, 6'(10 + k), 60, ty, 32'h1000_0000 + 32'(k * 4)),
                 erl, ZI, 16'(3 + k), EN && (k >= 4));
        end
        for (int k = 0; k < 2; k++)
            step("ovf_hold", Z, rl, ZI, Z, erl, ZI, 16'd8, EN);
        for (int k = 0; k < 4; k++)
            step("ovf_drain", Z, Z, ZI, Z,
                 EN ? mkerr(6'(10 + k), 32'h1000_0000 + 32'(k * 4)) : Z, ZI, 16'd8, EN);
        step("ovf_lost", Z, Z, ZI, Z, Z, ZI, 16'd8, EN);

        step("dual_exp_a", mk(20, 21, 62, PT_READ, 32'h600), mk(4, 2, 63, PT_ACK, 32'h604), ZI,
             mk(0, 21, 62, PT_READ, 32'h600), mk(0, 2, 63, PT_ACK, 32'h604), ZI, 16'd10, EN);
        step("dual_exp_b", mk(20, 22, 62, PT_WRITE, 32'h608), mk(4, 2, 63, PT_ACK, 32'h60C), ZI,
             mk(0, 22, 62, PT_WRITE, 32'h608),
             EN ? mkerr(21, 32'h600) : mk(0, 2, 63, PT_ACK, 32'h60C), ZI, 16'd12, EN);
        step("dual_exp_c", Z, Z, ZI, Z, EN ? mkerr(22, 32'h608) : Z, ZI, 16'd12, EN);

        // Park two responses in the FIFO, then reset mid-cycle.
        for (int k = 0; k < 2; k++)
            step("rst_fill", mk(20, 6'(30 + k), 60, PT_READ, 32'h700 + 32'(k * 4)), rl, ZI,
                 mk(0, 6'(30 + k), 60, PT_READ, 32'h700 + 32'(k * 4)), erl, ZI, 16'(13 + k), EN);
        step("rst_hold", Z, rl, ZI, Z, erl, ZI, 16'd14, EN);
        @(posedge clk);
        #3;
        rst = 1'b1;
        packet_i = Z; rpacket_i = Z; ipacket_i = ZI;
        #1;
        chk("async_reset", z);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++)
            step("post_rst_idle", Z, Z, ZI, Z, Z, ZI, 16'd0, 1'b0);

        // Two counted removals per cycle up to 16'hFFFE, then saturate.
        for (int i = 0; i < 32767; i++)
            drive(mk(8, 2, 60, PT_ACK, 0), mk(4, 2, 60, PT_ACK, 0), ZI);
        step("sat_reach", mk(8, 2, 60, PT_ACK, 0), mk(4, 2, 60, PT_ACK, 0), ZI,
             mk(0, 2, 60, PT_ACK, 0), mk(0, 2, 60, PT_ACK, 0), ZI, 16'hFFFF, 1'b0);
        step("sat_hold2", mk(8, 2, 60, PT_ACK, 0), mk(4, 2, 60, PT_ACK, 0), ZI,
             mk(0, 2, 60, PT_ACK, 0), mk(0, 2, 60, PT_ACK, 0), ZI, 16'hFFFF, 1'b0);
        step("sat_req", mk(9, 5, 60, PT_READ, 32'h800), Z, ZI,
             mk(0, 5, 60, PT_READ, 32'h800), Z, ZI, 16'hFFFF, 1'b0);
        step("sat_rsp", Z, Z, ZI, Z, EN ? mkerr(5, 32'h800) : Z, ZI, 16'hFFFF, 1'b0);

        drive(Z, Z, ZI);
        @(posedge clk);
        #2;
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d pending, exp 0", q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
